// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 fetch sequencer.
package rv32_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_PARK
  } state_e;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;
  localparam logic [31:0] FAULT_DATA = 32'h0;

endpackage

// File: rtl/rv32_fetch_sequencer.sv
// Fetch controller: owns the PC, issues one imem request at a time,
// holds each returned word for decode, handles redirects and faults.
module rv32_fetch_sequencer
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [31:0]       inst_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              fault_q, fault_d;
  logic [31:0]       count_q, count_d;
  logic              bubble_q, bubble_d;
  logic              drain_q, drain_d;

  logic req_fire;
  logic misalign;
  logic outstanding;

  assign imem_req_valid = (state_q == S_REQ) && !bubble_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = valid_q;
  assign inst_data      = data_q;
  assign inst_pc        = ipc_q;
  assign inst_fault     = fault_q;
  assign inst_count     = count_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign misalign = |(redirect_target[1:0] & ALIGN_MASK);

  // A response is still owed after this cycle: it must be eaten silently.
  assign outstanding =
    (state_q == S_REQ && req_fire) ||
    ((state_q == S_WAIT || state_q == S_DRAIN || drain_q) &&
     !imem_rsp_valid);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    fault_d  = fault_q;
    count_d  = count_q;
    bubble_d = 1'b0;
    drain_d  = drain_q;
    if (drain_q && imem_rsp_valid) drain_d = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      if (misalign) begin
        valid_d = 1'b1;
        fault_d = 1'b1;
        ipc_d   = redirect_target;
        data_d  = FAULT_DATA;
        state_d = S_HOLD;
        drain_d = outstanding;
      end else if (outstanding) begin
        state_d = S_DRAIN;
        drain_d = 1'b0;
      end else begin
        state_d  = S_REQ;
        drain_d  = 1'b0;
        bubble_d = (state_q == S_REQ) && !bubble_q;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (fetch_en) state_d = S_REQ;
        S_REQ:  if (req_fire) state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            valid_d = 1'b1;
            data_d  = imem_rsp_err ? FAULT_DATA : imem_rsp_data;
            ipc_d   = pc_q;
            fault_d = imem_rsp_err;
            pc_d    = pc_q + ADDR_W'(INST_BYTES);
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            count_d = count_q + 32'd1;
            valid_d = 1'b0;
            if (fault_q)       state_d = S_PARK;
            else if (fetch_en) state_d = S_REQ;
            else               state_d = S_IDLE;
          end
        end
        S_DRAIN: if (imem_rsp_valid) state_d = S_REQ;
        S_PARK:  state_d = S_PARK;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VECTOR[ADDR_W-1:0];
      valid_q  <= 1'b0;
      data_q   <= 32'h0;
      ipc_q    <= '0;
      fault_q  <= 1'b0;
      count_q  <= 32'h0;
      bubble_q <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ipc_q    <= ipc_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
      drain_q  <= drain_d;
    end
  end

endmodule

// File: tb/tb_rv32_fetch_sequencer.sv
// Directed bench for rv32_fetch_sequencer: vector table plus
// hand-written redirect, misalign and fault sequences.
module tb_rv32_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        mem_ready = 1'b1;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] inst_count;

  logic        auto_en = 1'b1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        auto_v, auto_e;
  logic [31:0] auto_d;
  logic        man_v = 1'b0;
  logic        man_e = 1'b0;
  logic [31:0] man_d = 32'h0;
  int          acc_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign imem_rsp_valid = auto_en ? auto_v : man_v;
  assign imem_rsp_data  = auto_en ? auto_d : man_d;
  assign imem_rsp_err   = auto_en ? auto_e : man_e;

  rv32_fetch_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fetch_en        (fetch_en),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (mem_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .imem_rsp_err    (imem_rsp_err),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_count      (inst_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1300_0000 | a;
  endfunction

  // One-cycle latency memory, plus an accept counter.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_v  <= 1'b0;
      auto_e  <= 1'b0;
      auto_d  <= 32'h0;
      acc_cnt <= 0;
    end else begin
      auto_v <= auto_en && imem_req_valid && mem_ready;
      auto_d <= mem_word(imem_req_addr);
      auto_e <= err_en && (imem_req_addr == err_addr);
      if (imem_req_valid && mem_ready) acc_cnt <= acc_cnt + 1;
    end
  end

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] a;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic fe, input logic rdy,
                              input logic rv, input logic [31:0] a,
                              input logic iv, input logic [31:0] pc,
                              input logic [31:0] cnt);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.a = a;
    v.iv = iv; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    man_v = 1'b0;
    #2;
    chk("rst_req_valid", 0, {31'h0, imem_req_valid}, 32'h0);
    chk("rst_inst", 0,
        {29'h0, inst_valid, inst_fault, |inst_data}, 32'h0);
    chk("rst_pc_cnt", 0, inst_pc | inst_count, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic chk_hold(input string nm, input logic [31:0] pc,
                          input logic [31:0] data, input logic flt);
    chk({nm, "_valid"}, 0, {31'h0, inst_valid}, 32'h1);
    chk({nm, "_pc"}, 0, inst_pc, pc);
    chk({nm, "_data"}, 0, inst_data, data);
    chk({nm, "_fault"}, 0, {31'h0, inst_fault}, {31'h0, flt});
  endtask

  initial begin
    int a0;
    bit hit;
    vt[0]  = mk(1, 1, 1, 32'h0,  0, 32'h0, 0);
    vt[1]  = mk(1, 1, 0, 32'h0,  0, 32'h0, 0);
    vt[2]  = mk(1, 1, 0, 32'h0,  1, 32'h0, 0);
    vt[3]  = mk(1, 1, 1, 32'h4,  0, 32'h0, 1);
    vt[4]  = mk(1, 1, 0, 32'h0,  0, 32'h0, 1);
    vt[5]  = mk(1, 1, 0, 32'h0,  1, 32'h4, 1);
    vt[6]  = mk(1, 0, 0, 32'h0,  1, 32'h4, 1);
    vt[7]  = mk(1, 0, 0, 32'h0,  1, 32'h4, 1);
    vt[8]  = mk(1, 0, 0, 32'h0,  1, 32'h4, 1);
    vt[9]  = mk(1, 0, 0, 32'h0,  1, 32'h4, 1);
    vt[10] = mk(1, 0, 0, 32'h0,  1, 32'h4, 1);
    vt[11] = mk(1, 1, 1, 32'h8,  0, 32'h0, 2);
    vt[12] = mk(1, 1, 0, 32'h0,  0, 32'h0, 2);
    vt[13] = mk(1, 1, 0, 32'h0,  1, 32'h8, 2);
    vt[14] = mk(1, 1, 1, 32'hC,  0, 32'h0, 3);
    vt[15] = mk(0, 1, 0, 32'h0,  0, 32'h0, 3);
    vt[16] = mk(0, 1, 0, 32'h0,  1, 32'hC, 3);
    vt[17] = mk(0, 1, 0, 32'h0,  0, 32'h0, 4);
    vt[18] = mk(0, 1, 0, 32'h0,  0, 32'h0, 4);
    vt[19] = mk(1, 1, 1, 32'h10, 0, 32'h0, 4);

    // Sequential fetch, decode stall, fetch_en gating
    auto_en = 1'b1;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      fetch_en = vt[i].fe;
      inst_ready = vt[i].rdy;
      tick();
      chk("vec_req_valid", i, {31'h0, imem_req_valid}, {31'h0, vt[i].rv});
      if (vt[i].rv) chk("vec_req_addr", i, imem_req_addr, vt[i].a);
      chk("vec_inst_valid", i, {31'h0, inst_valid}, {31'h0, vt[i].iv});
      if (vt[i].iv) begin
        chk("vec_inst_pc", i, inst_pc, vt[i].pc);
        chk("vec_inst_data", i, inst_data, mem_word(vt[i].pc));
      end
      chk("vec_count", i, inst_count, vt[i].cnt);
    end

    // Redirect in WAIT drops the stale response
    auto_en = 1'b0;
    do_reset();
    tick();
    chk("c_req0", 0, {31'h0, imem_req_valid}, 32'h1);
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("c_drain_req", 0, {31'h0, imem_req_valid}, 32'h0);
    man_v = 1'b1;
    man_d = 32'hDEAD_BEEF;
    tick();
    man_v = 1'b0;
    chk("c_stale_dropped", 0, {31'h0, inst_valid}, 32'h0);
    chk("c_req_valid", 0, {31'h0, imem_req_valid}, 32'h1);
    chk("c_req_addr", 0, imem_req_addr, 32'h100);
    tick();
    man_v = 1'b1;
    man_d = 32'h0000_0113;
    tick();
    man_v = 1'b0;
    chk_hold("c_hold", 32'h100, 32'h0000_0113, 1'b0);

    // Redirect beats inst_ready in HOLD
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("d_discard", 0, {31'h0, inst_valid}, 32'h0);
    chk("d_count", 0, inst_count, 32'h0);
    chk("d_req_addr", 0, imem_req_valid ? imem_req_addr : 32'hFFFF_FFFF,
        32'h200);
    tick();
    man_v = 1'b1;
    man_d = 32'h0000_0222;
    tick();
    man_v = 1'b0;
    chk_hold("d_hold", 32'h200, 32'h0000_0222, 1'b0);
    tick();
    chk("d_count1", 0, inst_count, 32'h1);
    chk("d_next_addr", 0, imem_req_addr, 32'h204);

    // Misaligned redirect faults without a memory access, then parks
    mem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    a0 = acc_cnt;
    tick();
    redirect_valid = 1'b0;
    chk_hold("e_mis", 32'h102, 32'h0, 1'b1);
    chk("e_no_req", 0, {31'h0, imem_req_valid}, 32'h0);
    mem_ready = 1'b1;
    tick();
    chk("e_count", 0, inst_count, 32'h2);
    chk("e_park_valid", 0, {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("e_park_noacc", 0, acc_cnt - a0, 0);
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk("e_resume_addr", 0,
        imem_req_valid ? imem_req_addr : 32'hFFFF_FFFF, 32'h300);
    tick();
    man_v = 1'b1;
    man_d = 32'h0000_0333;
    tick();
    man_v = 1'b0;
    chk_hold("e_hold", 32'h300, 32'h0000_0333, 1'b0);

    // Access fault at 0x8 parks until redirect
    auto_en = 1'b1;
    err_en = 1'b1;
    err_addr = 32'h8;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      hit = inst_valid && inst_pc == 32'h8;
    end
    chk("f_reached", 0, {31'h0, hit}, 32'h1);
    chk_hold("f_err", 32'h8, 32'h0, 1'b1);
    tick();
    a0 = acc_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("f_park_noacc", 0, acc_cnt - a0, 0);
    chk("f_park_valid", 0, {31'h0, inst_valid | imem_req_valid}, 32'h0);
    chk("f_count", 0, inst_count, 32'h3);
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("f_resume_addr", 0,
        imem_req_valid ? imem_req_addr : 32'hFFFF_FFFF, 32'h40);
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h500;
    tick();
    redirect_valid = 1'b0;
    chk("f_rsp_vs_redir", 0, {31'h0, inst_valid}, 32'h0);
    chk("f_redir_addr", 0,
        imem_req_valid ? imem_req_addr : 32'hFFFF_FFFF, 32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
